peripheral_uart_rx: RTL



---
 rtl/peripheral_uart_rx_if.sv | 40 ++++
 rtl/peripheral_uart_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_uart_rx_if.sv
// -----------------------------------------------------------------------------
// peripheral_uart_rx_if
//   J1 I/O bus connection for the UART receiver peripheral.
//
//   d_in   [15:0]  write data from the CPU
//   cs             chip select from the top-level address decoder
//   addr   [3:0]   register offset (j1_io_addr[3:0])
//   rd             read strobe
//   wr             write strobe
//   d_out  [15:0]  read data returned by the peripheral
//
//   master : CPU / decoder side
//   slave  : peripheral side
// -----------------------------------------------------------------------------
interface peripheral_uart_rx_if;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;

    modport master (
        output d_in,
        output cs,
        output addr,
        output rd,
        output wr,
        input  d_out
    );

    modport slave (
        input  d_in,
        input  cs,
        input  addr,
        input  rd,
        input  wr,
        output d_out
    );
endinterface

// File: rtl/peripheral_uart_rx.sv
// -----------------------------------------------------------------------------
// peripheral_uart_rx
//   Memory-mapped UART receiver on the J1 I/O bus. The asynchronous serial
//   line is synchronised, 8N1 frames are deserialised by a small FSM that
//   samples each bit at its midpoint, and received bytes are buffered in a
//   2**FIFO_AW entry FIFO that firmware drains by polling.
//
//   Ports
//     clk       system clock
//     rst       synchronous active-high reset
//     bus       J1 peripheral bus (slave side): d_in, cs, addr, rd, wr, d_out
//     uart_rx   asynchronous serial input, idle high
//     rx_avail  high while the FIFO holds at least one byte
//
//   Register map (addr)
//     0x0 DATA   R  {8'h00, head}; a read pops one byte when non-empty,
//                   an empty read returns 0 and does not pop
//     0x2 STATUS R  [0] not_empty [1] full [2] overrun [3] frame_err
//                   [4+FIFO_AW:4] count; no side effects
//     0x4 CTRL   W  [0] clear overrun/frame_err, [1] flush FIFO
//
//   clkFreq/baudRate must be at least 4 so that the half-bit wait and the
//   full-bit wait are distinct, non-zero intervals.
// -----------------------------------------------------------------------------
module peripheral_uart_rx #(
    parameter int clkFreq  = 100000000,
    parameter int baudRate = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    peripheral_uart_rx_if.slave   bus,
    input  logic                  uart_rx,
    output logic                  rx_avail
);

    localparam int BIT_DIV = clkFreq / baudRate;
    localparam int HALF    = BIT_DIV / 2;
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int CNT_W   = $clog2(BIT_DIV);

    localparam logic [CNT_W-1:0]   CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BIT_DIV - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h2;
    localparam logic [3:0] ADDR_CTRL   = 4'h4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchroniser: rx_sync_p0 may go metastable, rxs is the clean copy.
    // Both reset high so a reset never manufactures a start bit.
    // -------------------------------------------------------------------------
    logic rx_sync_p0;
    logic rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_p0 <= 1'b1;
            rxs        <= 1'b1;
        end else begin
            rx_sync_p0 <= uart_rx;
            rxs        <= rx_sync_p0;
        end
    end

    // -------------------------------------------------------------------------
    // Receiver FSM
    // -------------------------------------------------------------------------
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bidx;
    logic [7:0]       shift;
    logic             bit_end;

    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            bidx  <= '0;
            shift <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state <= START;
                    end
                end

                // Re-check the line half a bit later; a short low pulse is
                // dropped silently instead of being treated as a frame.
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        bidx  <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // From here every sample lands one full bit after the
                // mid-start point, i.e. in the middle of each data bit.
                DATA: begin
                    if (bit_end) begin
                        cnt         <= '0;
                        shift[bidx] <= rxs;
                        if (bidx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bidx <= bidx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Leaving at mid-stop lets a following start bit be caught
                // even when frames are sent back to back.
                STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FIFO request decode
    // -------------------------------------------------------------------------
    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic             overrun;
    logic             frame_err;

    logic not_empty;
    logic full;
    logic push_req;
    logic ferr_set;
    logic pop_req;
    logic ctrl_wr;
    logic flush;
    logic clr;
    logic push_ok;
    logic pop_ok;
    logic ovr_set;

    assign not_empty = (count != '0);
    assign full      = (count == CNT_FULL);

    assign push_req  = (state == STOP) && bit_end && rxs;
    assign ferr_set  = (state == STOP) && bit_end && !rxs;

    assign pop_req   = bus.cs && bus.rd && (bus.addr == ADDR_DATA) && not_empty;
    assign ctrl_wr   = bus.cs && bus.wr && (bus.addr == ADDR_CTRL);
    assign flush     = ctrl_wr && bus.d_in[1];
    assign clr       = ctrl_wr && bus.d_in[0];

    // A simultaneous pop frees the slot, so a push into a full FIFO is still
    // accepted in that cycle. Flush overrides both sides.
    assign push_ok   = push_req && (!full || pop_req) && !flush;
    assign pop_ok    = pop_req && !flush;
    assign ovr_set   = push_req && full && !pop_req && !flush;

    logic unused_d_in;
    assign unused_d_in = ^bus.d_in[15:2];

    // -------------------------------------------------------------------------
    // FIFO storage (data only, not reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shift;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointers, occupancy and sticky flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push_ok, pop_ok})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            // A new error event in the same cycle as a clear keeps the flag.
            overrun   <= ovr_set  | (overrun   & ~clr);
            frame_err <= ferr_set | (frame_err & ~clr);
        end
    end

    // -------------------------------------------------------------------------
    // Read mux
    // -------------------------------------------------------------------------
    logic [15:0] status;

    always_comb begin
        status                  = '0;
        status[0]               = not_empty;
        status[1]               = full;
        status[2]               = overrun;
        status[3]               = frame_err;
        status[4 +: FIFO_AW+1]  = count;
    end

    always_comb begin
        bus.d_out = '0;
        case (bus.addr)
            ADDR_DATA: begin
                if (not_empty) begin
                    bus.d_out = {8'h00, mem[rd_ptr]};
                end
            end
            ADDR_STATUS: bus.d_out = status;
            default:     bus.d_out = '0;
        endcase
    end

    assign rx_avail = not_empty;

endmodule
